ksort_controller: RTL

//  Query sequencer for the k-smallest insertion-sort array (kSorting).
//  - Per query: clears the sorter, streams N candidate (name,value) pairs into it, waits out the

---
 rtl/ksort_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ksort_controller.sv
// Query sequencer for the k-smallest insertion-sort array: clear, load N candidates, flush, drain min(k,N).
// Optional KSORT_PERF_CNT_EN adds a per-query busy-cycle counter on perf_cycles.
module ksort_controller #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_K        = 1024,
  parameter int CLEAR_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           k,
  input  logic [31:0]           n_items,
  output logic                  busy,
  output logic                  k_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_name,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic                  sort_clear,
  output logic                  sort_valid,
  output logic [31:0]           sort_k,
  output logic [31:0]           sort_name,
  output logic [DATA_WIDTH-1:0] sort_value,
  output logic                  sort_pop,
  input  logic [31:0]           sort_name_out,
  input  logic [DATA_WIDTH-1:0] sort_value_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_name,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_last,
  output logic                  done
`ifdef KSORT_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] MAX_K_W    = 32'(MAX_K);
  localparam logic [3:0]  CLEAR_INIT = 4'(CLEAR_CYCLES - 1);
  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit          FLUSH_SKIP = (FLUSH_CYCLES == 0);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] n_rem;
  logic [31:0] d_rem;
  logic [31:0] k_eff;
  logic        k_err_r;

  logic [31:0] k_clamp;
  logic        in_fire;
  logic        out_fire;

  assign k_clamp  = (k > MAX_K_W) ? MAX_K_W : k;
  assign in_fire  = (state == LOAD) && in_valid;
  assign out_fire = (state == DRAIN) && out_ready;

  // Query sequencing; all per-query bookkeeping is latched when start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      n_rem    <= '0;
      d_rem    <= '0;
      k_eff    <= '0;
      k_err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            wait_cnt <= CLEAR_INIT;
            k_eff    <= k_clamp;
            k_err_r  <= (k > MAX_K_W);
            n_rem    <= n_items;
            d_rem    <= (k_clamp < n_items) ? k_clamp : n_items;
          end
        end
        CLEAR: begin
          if (wait_cnt == 4'd0) begin
            state <= (n_rem != 32'd0) ? LOAD : DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        LOAD: begin
          if (in_fire) begin
            n_rem <= n_rem - 32'd1;
            if (n_rem == 32'd1) begin
              if (FLUSH_SKIP) begin
                state <= (d_rem != 32'd0) ? DRAIN : DONE;
              end else begin
                state    <= FLUSH;
                wait_cnt <= FLUSH_INIT;
              end
            end
          end
        end
        FLUSH: begin
          if (wait_cnt == 4'd0) begin
            state <= (d_rem != 32'd0) ? DRAIN : DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            d_rem <= d_rem - 32'd1;
            if (d_rem == 32'd1) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sorter is held in clear for the whole of reset, not just the CLEAR state.
  assign sort_clear = reset || (state == CLEAR);
  assign busy       = (state != IDLE);
  assign in_ready   = (state == LOAD);
  assign sort_valid = in_fire;
  assign sort_name  = in_fire ? in_name : '0;
  assign sort_value = in_fire ? in_value : '0;
  assign sort_k     = k_eff;
  assign k_err      = k_err_r;
  assign out_valid  = (state == DRAIN);
  assign out_last   = (state == DRAIN) && (d_rem == 32'd1);
  assign out_name   = out_valid ? sort_name_out : '0;
  assign out_value  = out_valid ? sort_value_out : '0;
  assign sort_pop   = out_fire;
  assign done       = (state == DONE);

`ifdef KSORT_PERF_CNT_EN
  // Counts busy cycles including DONE, then holds until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
